// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared definitions for the instruction-memory boot loader.
//   state_t    - loader FSM states
//   WORD_BYTES - bytes per instruction word
//   CHK_SEED   - initial value of the trailer XOR accumulator
package im_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [7:0]  CHK_SEED   = 8'h00;

endpackage

// File: rtl/im_word_assembler.sv
// im_word_assembler: little-endian byte-to-word shift register.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - discard any partial word and restart at byte 0
//   shift       - shift din into the word this cycle
//   din         - incoming byte
//   word        - assembled word; first byte of a word ends up in [7:0]
//   word_full   - the shift happening this cycle completes a word
module im_word_assembler
    import im_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_full
);

    localparam logic [1:0] LAST = 2'(WORD_BYTES - 1);

    logic [1:0] cnt;

    // Combinational so the loader can leave DATA on the same edge that
    // accepts the final byte.
    assign word_full = shift && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (clear) begin
            word <= '0;
            cnt  <= '0;
        end else if (shift) begin
            word <= {din, word[31:8]};
            cnt  <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/im_loader.sv
// im_loader: boot loader writing a byte stream into instruction RAM.
// Stream: header byte N (word count), then N*4 little-endian data bytes.
// Optional build macro IM_LOADER_CHECKSUM_EN adds a trailer byte holding
// the XOR of header and data bytes; a mismatch ends the session in ERR.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - one-cycle pulse, begins a session when not busy
//   byte_in/byte_valid  - byte source
//   byte_ready          - loader accepts a byte this cycle
//   we/waddr/wdata      - instruction RAM write port
//   busy/done/error     - session status
//   cpu_hold            - holds the CPU in reset until a load completes
//   word_count          - words written in the current session
module im_loader
    import im_loader_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 5,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  we,
    output logic [ADDR_BITS-1:0]  waddr,
    output logic [WORD_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold,
    output logic [ADDR_BITS:0]    word_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

`ifdef IM_LOADER_CHECKSUM_EN
    localparam state_t FINAL_ST = CHK;
`else
    localparam state_t FINAL_ST = DONE;
`endif

    state_t               state;
    state_t               state_nx;
    logic                 hs;
    logic                 session_start;
    logic                 load_n;
    logic                 asm_shift;
    logic                 asm_full;
    logic [31:0]          asm_word;
    logic [ADDR_BITS:0]   n_words;
    logic [ADDR_BITS:0]   wc_inc;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]           chk_acc;
`endif

    assign hs            = byte_valid && byte_ready;
    assign session_start = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign asm_shift     = hs && (state == DATA);
    assign wc_inc        = word_count + {{ADDR_BITS{1'b0}}, 1'b1};

    // wdata comes straight from the assembler register; it is stable during
    // WRITE because no byte is accepted in that state.
    assign wdata = asm_word;

    im_word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (session_start),
        .shift     (asm_shift),
        .din       (byte_in),
        .word      (asm_word),
        .word_full (asm_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load_n   = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nx = HDR;
            end
            HDR: begin
                if (hs) begin
                    load_n = 1'b1;
                    if (byte_in == 8'h00)          state_nx = FINAL_ST;
                    else if (32'(byte_in) > DEPTH) state_nx = ERR;
                    else                           state_nx = DATA;
                end
            end
            DATA: begin
                if (asm_full) state_nx = WRITE;
            end
            WRITE: begin
                state_nx = (wc_inc == n_words) ? FINAL_ST : DATA;
            end
`ifdef IM_LOADER_CHECKSUM_EN
            CHK: begin
                if (hs) state_nx = (byte_in == chk_acc) ? DONE : ERR;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are registered
    // and still line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_ready <= 1'b0;
            we         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
            waddr      <= '0;
            word_count <= '0;
            n_words    <= '0;
        end else begin
            byte_ready <= (state_nx == HDR) || (state_nx == DATA) || (state_nx == CHK);
            busy       <= (state_nx == HDR) || (state_nx == DATA) ||
                          (state_nx == WRITE) || (state_nx == CHK);
            done       <= (state_nx == DONE);
            error      <= (state_nx == ERR);
            cpu_hold   <= (state_nx != DONE);
            we         <= (state_nx == WRITE);
            if (state_nx == WRITE) waddr <= word_count[ADDR_BITS-1:0];
            if (session_start)       word_count <= '0;
            else if (state == WRITE) word_count <= wc_inc;
            if (load_n) n_words <= (ADDR_BITS+1)'(byte_in);
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_acc <= CHK_SEED;
        end else if (session_start) begin
            chk_acc <= CHK_SEED;
        end else if (hs && ((state == HDR) || (state == DATA))) begin
            chk_acc <= chk_acc ^ byte_in;
        end
    end
`endif

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;
    logic [5:0]  word_count;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  xacc;
    logic [4:0]  exp_addr;

    im_loader #(.ADDR_BITS(5), .WORD_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endfunction

    // Write monitor: every we pulse must match the next queued write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_we", {27'd0, waddr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("waddr", {27'd0, waddr}, {27'd0, e.addr});
                    check("wdata", wdata, e.data);
                    check("ready_in_write", {31'd0, byte_ready}, 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offers a byte (optionally with random idle cycles) until it is taken.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int unsigned cyc = 0;
        bit sent = 1'b0;
        while (!sent) begin
            byte_in    = b;
            byte_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (byte_valid && byte_ready) sent = 1'b1;
            tick();
            cyc++;
            if (!sent && cyc > 200) begin
                total++;
                bad++;
                $display("FAIL byte_accept: byte 0x%02h not taken within %0d cycles", b, cyc);
                sent = 1'b1;
            end
        end
        byte_valid = 1'b0;
        xacc = xacc ^ b;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        exp_q.push_back({exp_addr, w});
        exp_addr = exp_addr + 5'd1;
        send_byte(w[7:0], gaps);
        send_byte(w[15:8], gaps);
        send_byte(w[23:16], gaps);
        send_byte(w[31:24], gaps);
        check("we_latency", {31'd0, we}, 32'd1);
    endtask

    task automatic begin_session(input logic [7:0] n, input bit gaps);
        pulse_start();
        xacc     = 8'h00;
        exp_addr = 5'd0;
        send_byte(n, gaps);
    endtask

`ifdef IM_LOADER_CHECKSUM_EN
    task automatic send_trailer(input bit good);
        logic [7:0] t;
        t = good ? xacc : (xacc ^ 8'h01);
        send_byte(t, 1'b0);
    endtask
`endif

    task automatic wait_end();
        int unsigned n = 0;
        @(negedge clk);
        while (!(done || error) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) begin
            total++;
            bad++;
            $display("FAIL session_end: no done/error after %0d cycles", n);
        end
    endtask

    task automatic check_status(input string name, input logic d, input logic e, input logic h,
                                input logic [5:0] wc);
        check(name, {28'd0, done, error, cpu_hold, busy}, {28'd0, d, e, h, 1'b0});
        check("word_count", {26'd0, word_count}, {26'd0, wc});
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {26'd0, byte_ready, we, busy, done, error, cpu_hold}, 32'h0000_0001);
        check("rst_waddr", {27'd0, waddr}, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_word_count", {26'd0, word_count}, 32'd0);
    endtask

    task automatic probe_no_accept(input string name);
        for (int i = 0; i < 3; i++) begin
            byte_in    = 8'hFF;
            byte_valid = 1'b1;
            @(negedge clk);
            check(name, {31'd0, byte_ready}, 32'd0);
            tick();
        end
        byte_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        xacc       = 8'h00;
        exp_addr   = 5'd0;
        tick();
        tick();
        check_reset_vals("reset_outputs");
        rst_n = 1'b1;
        tick();

        // Basic load, with a start pulse during DATA that must be ignored.
        begin_session(8'h02, 1'b0);
        send_word(32'h0000_0293, 1'b0);
        tick();
        pulse_start();
        send_word(32'h0000_0393, 1'b0);
`ifdef IM_LOADER_CHECKSUM_EN
        send_trailer(1'b1);
`endif
        wait_end();
        check_status("basic_status", 1'b1, 1'b0, 1'b0, 6'd2);
        tick();
        probe_no_accept("done_ready");

        // Empty image: done the cycle after the header (or trailer) handshake.
        begin_session(8'h00, 1'b0);
`ifdef IM_LOADER_CHECKSUM_EN
        send_trailer(1'b1);
`endif
        @(negedge clk);
        check_status("empty_status", 1'b1, 1'b0, 1'b0, 6'd0);
        tick();

        // Oversize header, then recovery.
        begin_session(8'h21, 1'b0);
        @(negedge clk);
        check_status("oversize_status", 1'b0, 1'b1, 1'b1, 6'd0);
        tick();
        probe_no_accept("err_ready");
        begin_session(8'h01, 1'b0);
        send_word(32'h0000_0013, 1'b0);
`ifdef IM_LOADER_CHECKSUM_EN
        send_trailer(1'b1);
`endif
        wait_end();
        check_status("recover_status", 1'b1, 1'b0, 1'b0, 6'd1);
        tick();

        // Backpressure and gaps.
        begin_session(8'h01, 1'b1);
        send_word(32'h1001_05B7, 1'b1);
`ifdef IM_LOADER_CHECKSUM_EN
        send_trailer(1'b1);
`endif
        wait_end();
        check_status("gaps_status", 1'b1, 1'b0, 1'b0, 6'd1);
        tick();

        // Full RAM, then the next session wraps back to address 0.
        begin_session(8'h20, 1'b0);
        for (int unsigned i = 0; i < 32; i++) begin
            send_word(32'hA5C3_0000 | (i * 32'h0101), 1'b0);
        end
`ifdef IM_LOADER_CHECKSUM_EN
        send_trailer(1'b1);
`endif
        wait_end();
        check_status("full_status", 1'b1, 1'b0, 1'b0, 6'd32);
        tick();
        begin_session(8'h01, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0);
`ifdef IM_LOADER_CHECKSUM_EN
        send_trailer(1'b1);
`endif
        wait_end();
        check_status("wrap_status", 1'b1, 1'b0, 1'b0, 6'd1);
        tick();

        // Reset in the middle of word 1.
        begin_session(8'h02, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst_outputs");
        tick();
        tick();
        check_reset_vals("midrst_held");
        rst_n = 1'b1;
        tick();
        begin_session(8'h01, 1'b0);
        send_word(32'h0000_ABCD, 1'b0);
`ifdef IM_LOADER_CHECKSUM_EN
        send_trailer(1'b1);
`endif
        wait_end();
        check_status("after_rst_status", 1'b1, 1'b0, 1'b0, 6'd1);
        tick();

`ifdef IM_LOADER_CHECKSUM_EN
        // Checksum: header 01, bytes 13 00 00 00 -> trailer 12 good, 13 bad.
        begin_session(8'h01, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_byte(8'h12, 1'b0);
        wait_end();
        check_status("chk_good_status", 1'b1, 1'b0, 1'b0, 6'd1);
        tick();
        begin_session(8'h01, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_byte(8'h13, 1'b0);
        wait_end();
        check_status("chk_bad_status", 1'b0, 1'b1, 1'b1, 6'd1);
        tick();
`endif

        repeat (5) tick();
        check("sb_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
